// File: rtl/ice40_reset_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ice40_reset_seq : staged, synchronously released resets for iCE40 designs
// Revision 1.0
// ---------------------------------------------------------------------------
module ice40_reset_seq #(
  parameter int NUM_CHAN    = 4,
  parameter int HOLD_CYCLES = 255,
  parameter int STAGE_GAP   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                pll_lock,
  input  logic                soft_rst_req,
  output logic [NUM_CHAN-1:0] chan_resetn,
  output logic                all_released,
  output logic                busy,
  output logic [1:0]          rst_cause
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int IW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;

  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_CHAN - 1);
  localparam logic [1:0]    CAUSE_POR  = 2'd0;
  localparam logic [1:0]    CAUSE_SOFT = 2'd1;
  localparam logic [1:0]    CAUSE_LOCK = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HOLD    = 2'd1,
    S_RELEASE = 2'd2,
    S_RUN     = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   rst_sync;
  logic                   lock_s;

  state_e                 state_q, state_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NUM_CHAN-1:0]    chan_q, chan_d;
  logic [1:0]             cause_q, cause_d;

  // Both chains clear asynchronously; deassertion of resetn reaches the FSM only through rst_sync.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_sync_q  <= '0;
      lock_sync_q <= '0;
    end else begin
      rst_sync_q  <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_lock};
    end
  end

  assign rst_sync = rst_sync_q[SYNC_STAGES-1];
  assign lock_s   = lock_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      chan_q  <= '0;
      cause_q <= CAUSE_POR;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      chan_q  <= chan_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    chan_d  = chan_q;
    cause_d = cause_q;

    case (state_q)
      S_IDLE: begin
        chan_d = '0;
        if (rst_sync && lock_s) begin
          state_d = S_HOLD;
          hold_d  = '0;
        end
      end

      S_HOLD: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HOLD_LAST) begin
          chan_d[0] = 1'b1;
          hold_d    = '0;
          if (NUM_CHAN == 1) begin
            state_d = S_RUN;
          end else begin
            state_d = S_RELEASE;
            idx_d   = IW'(1);
            gap_d   = '0;
          end
        end
      end

      S_RELEASE: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          for (int k = 0; k < NUM_CHAN; k++) begin
            if (idx_q == IW'(k)) chan_d[k] = 1'b1;
          end
          if (idx_q == IDX_LAST) begin
            state_d = S_RUN;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      S_RUN: begin
        chan_d = '1;
      end

      default: begin
        state_d = S_IDLE;
        chan_d  = '0;
      end
    endcase

    // Lock loss takes priority over a simultaneous soft request.
    if (state_q != S_IDLE) begin
      if (!lock_s) begin
        state_d = S_IDLE;
        chan_d  = '0;
        hold_d  = '0;
        gap_d   = '0;
        idx_d   = '0;
        cause_d = CAUSE_LOCK;
      end else if (soft_rst_req) begin
        state_d = S_HOLD;
        chan_d  = '0;
        hold_d  = '0;
        gap_d   = '0;
        idx_d   = '0;
        cause_d = CAUSE_SOFT;
      end
    end
  end

  assign chan_resetn  = chan_q;
  assign all_released = (state_q == S_RUN);
  assign busy         = (state_q != S_RUN);
  assign rst_cause    = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_ice40_reset_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ice40_reset_seq : checks two configurations against a closed-form timing model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_ice40_reset_seq;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       pll_lock = 1'b1;
  logic       soft_rst_req = 1'b0;
  logic [2:0] chan_a;
  logic       allrel_a, busy_a;
  logic [1:0] cause_a;
  logic [0:0] chan_b;
  logic       allrel_b, busy_b;
  logic [1:0] cause_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ice40_reset_seq #(.NUM_CHAN(3), .HOLD_CYCLES(8), .STAGE_GAP(4), .SYNC_STAGES(S)) u_a (
    .clk(clk), .resetn(resetn), .pll_lock(pll_lock), .soft_rst_req(soft_rst_req),
    .chan_resetn(chan_a), .all_released(allrel_a), .busy(busy_a), .rst_cause(cause_a)
  );

  ice40_reset_seq #(.NUM_CHAN(1), .HOLD_CYCLES(1), .STAGE_GAP(1), .SYNC_STAGES(S)) u_b (
    .clk(clk), .resetn(resetn), .pll_lock(pll_lock), .soft_rst_req(soft_rst_req),
    .chan_resetn(chan_b), .all_released(allrel_b), .busy(busy_b), .rst_cause(cause_b)
  );

  // Model: edges counted from resetn release; channel k of a running sequence
  // started at edge st is released once (edge - st) >= HOLD + k*GAP.
  int m_nc[2] = '{3, 1};
  int m_h[2]  = '{8, 1};
  int m_g[2]  = '{4, 1};
  bit m_ins[2];
  int m_st[2];
  int m_cause[2];
  int n;
  bit lhist[$];

  function automatic logic [2:0] exp_chan(int d, int e);
    logic [2:0] r;
    r = '0;
    for (int k = 0; k < m_nc[d]; k++)
      r[k] = m_ins[d] && ((e - m_st[d]) >= (m_h[d] + k * m_g[d]));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0;
    lhist.delete();
    for (int d = 0; d < 2; d++) begin
      m_ins[d]   = 1'b0;
      m_st[d]    = 0;
      m_cause[d] = 0;
    end
  endtask

  task automatic step(input string tag, output int e);
    bit lk;
    logic [2:0] ec;
    logic       all;
    @(posedge clk);
    e = n;
    lhist.push_back(pll_lock);
    lk = (e >= S) ? lhist[e-S] : 1'b0;
    for (int d = 0; d < 2; d++) begin
      if (!m_ins[d]) begin
        if (e >= S && lk) begin
          m_ins[d] = 1'b1;
          m_st[d]  = e;
        end
      end else if (!lk) begin
        m_ins[d]   = 1'b0;
        m_cause[d] = 2;
      end else if (soft_rst_req) begin
        m_st[d]    = e;
        m_cause[d] = 1;
      end
    end
    n++;
    #1;
    ec  = exp_chan(0, e);
    all = (ec == 3'b111);
    chk($sformatf("%s a.chan E%0d", tag, e), 32'(chan_a), 32'(ec));
    chk($sformatf("%s a.all E%0d", tag, e), 32'(allrel_a), 32'(all));
    chk($sformatf("%s a.busy E%0d", tag, e), 32'(busy_a), 32'(!all));
    chk($sformatf("%s a.cause E%0d", tag, e), 32'(cause_a), 32'(m_cause[0]));
    ec  = exp_chan(1, e);
    all = ec[0];
    chk($sformatf("%s b.chan E%0d", tag, e), 32'(chan_b), 32'(ec[0]));
    chk($sformatf("%s b.all E%0d", tag, e), 32'(allrel_b), 32'(all));
    chk($sformatf("%s b.busy E%0d", tag, e), 32'(busy_b), 32'(!all));
    chk($sformatf("%s b.cause E%0d", tag, e), 32'(cause_b), 32'(m_cause[1]));
  endtask

  // Asserts resetn between edges, checks the asynchronous clear, then releases just after an edge.
  task automatic do_reset(input string tag, input int cycles);
    resetn = 1'b0;
    #1;
    chk({tag, " rst a.chan"}, 32'(chan_a), 32'd0);
    chk({tag, " rst a.all"}, 32'(allrel_a), 32'd0);
    chk({tag, " rst a.busy"}, 32'(busy_a), 32'd1);
    chk({tag, " rst a.cause"}, 32'(cause_a), 32'd0);
    chk({tag, " rst b.chan"}, 32'(chan_b), 32'd0);
    chk({tag, " rst b.busy"}, 32'(busy_b), 32'd1);
    repeat (cycles) @(posedge clk);
    #1;
    resetn = 1'b1;
    model_reset();
  endtask

  initial begin
    int e;
    model_reset();
    #2;

    // Power-up sequence with lock already stable
    do_reset("por", 3);
    for (int i = 0; i < 30; i++) begin
      step("seq", e);
      if (e == 2)  chk("spec b.ch0 low E2", 32'(chan_b), 32'd0);
      if (e == 3)  chk("spec b.ch0 up E3", 32'(chan_b), 32'd1);
      if (e == 9)  chk("spec a.chan E9", 32'(chan_a), 32'b000);
      if (e == 10) chk("spec a.chan E10", 32'(chan_a), 32'b001);
      if (e == 14) chk("spec a.chan E14", 32'(chan_a), 32'b011);
      if (e == 17) chk("spec a.all E17", 32'(allrel_a), 32'd0);
      if (e == 18) chk("spec a.all E18", 32'(allrel_a), 32'd1);
    end

    // One-cycle soft request at E30
    soft_rst_req = 1'b1;
    step("soft", e);
    soft_rst_req = 1'b0;
    chk("spec a.chan E30", 32'(chan_a), 32'b000);
    for (int i = 0; i < 20; i++) begin
      step("soft", e);
      if (e == 38) chk("spec a.chan E38", 32'(chan_a), 32'b001);
      if (e == 42) chk("spec a.chan E42", 32'(chan_a), 32'b011);
      if (e == 46) chk("spec a.chan E46", 32'(chan_a), 32'b111);
      if (e == 46) chk("spec a.cause E46", 32'(cause_a), 32'd1);
    end

    // Lock loss during RUN, dropped just after E50
    pll_lock = 1'b0;
    for (int i = 0; i < 13; i++) begin
      step("lock", e);
      if (e == 52) chk("spec a.chan E52", 32'(chan_a), 32'b111);
      if (e == 53) chk("spec a.chan E53", 32'(chan_a), 32'b000);
      if (e == 53) chk("spec a.cause E53", 32'(cause_a), 32'd2);
    end
    pll_lock = 1'b1;
    for (int i = 0; i < 30; i++) step("relock", e);

    // Async reset in the middle of RELEASE, then a clean restart
    do_reset("mid", 2);
    for (int i = 0; i < 16; i++) step("pre", e);
    do_reset("midrel", 3);
    for (int i = 0; i < 25; i++) step("post", e);

    // Soft request and lock loss coinciding during HOLD; soft held through IDLE
    do_reset("both", 2);
    for (int i = 0; i < 5; i++) step("hold", e);
    soft_rst_req = 1'b1;
    pll_lock     = 1'b0;
    for (int i = 0; i < 8; i++) step("both", e);
    chk("both a.cause", 32'(cause_a), 32'd2);
    pll_lock = 1'b1;
    for (int i = 0; i < 6; i++) step("softhi", e);
    soft_rst_req = 1'b0;
    for (int i = 0; i < 30; i++) step("drain", e);

    // Randomised soft requests, lock glitches and resets
    for (int i = 0; i < 1500; i++) begin
      step("rand", e);
      soft_rst_req = ($urandom % 24) == 0;
      if (($urandom % 60) == 0) pll_lock = ~pll_lock;
      if (($urandom % 300) == 0) do_reset("rand", int'($urandom_range(1, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
